// File: rtl/instruction_sequencer.sv
// ---------------------------------------------------------------------------
// instruction_sequencer
//   Multi-cycle instruction sequencer. It walks each instruction through the
//   IF -> MR -> RU -> MW -> PCU stages and fetches instructions and operand
//   words over a simple req/ready read port.
//
//   Optional feature macro: STAGE_SKIP_EN
//     When defined, non-memory opcodes go IF -> RU, skipping MR, and every
//     opcode goes RU -> PCU, skipping MW.
//
//   Ports
//     clk, rst                   clock, asynchronous active-high reset
//     mem_req, mem_addr          read request and word address (registered)
//     mem_ready, mem_rdata       read accept strobe and returned data
//     stage                      current stage code (IF=0 MR=1 RU=2 MW=3 PCU=4)
//     current_instruction_type   opcode field of the held instruction
//     load_imm_reg, load_mem_reg,
//     alu_op_reg_0, alu_op_reg_1,
//     alu_op_reg_res             decoded register fields
//     load_imm_data, load_mem_data  operand words latched during MR
//     alu_op                     ALU function select
//     pc                         word address of the current instruction
//     halted                     set once HALT retires
// ---------------------------------------------------------------------------
module instruction_sequencer (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  stage,
  output logic [4:0]  current_instruction_type,
  output logic [4:0]  load_imm_reg,
  output logic [4:0]  load_mem_reg,
  output logic [4:0]  alu_op_reg_0,
  output logic [4:0]  alu_op_reg_1,
  output logic [4:0]  alu_op_reg_res,
  output logic [31:0] load_imm_data,
  output logic [31:0] load_mem_data,
  output logic [5:0]  alu_op,
  output logic [31:0] pc,
  output logic        halted
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 5;

  localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_LD   = OPW'(2);
  localparam logic [OPW-1:0] OP_HALT = OPW'(7);

`ifdef STAGE_SKIP_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_MR  = 3'd1,
    ST_RU  = 3'd2,
    ST_MW  = 3'd3,
    ST_PCU = 3'd4
  } stage_e;

  stage_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [XLEN-1:0]   ldm_q, ldm_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              halted_q, halted_d;

  logic [OPW-1:0]    op_q;
  logic [OPW-1:0]    op_in;
  logic [XLEN-1:0]   load_addr;
  logic              accept;

  // Opcodes that need an operand word fetched in MR
  function automatic logic needs_mem(input logic [OPW-1:0] op);
    return (op == OP_LDI) || (op == OP_LD);
  endfunction

  assign op_q      = ir_q[4:0];
  assign op_in     = mem_rdata[4:0];
  assign load_addr = XLEN'(ir_q[31:15]);
  // A read completes only when our own request is outstanding
  assign accept    = mem_req_q && mem_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IF;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IF: begin
        if (accept) begin
          if (SkipEn && !needs_mem(op_in)) state_d = ST_RU;
          else                             state_d = ST_MR;
        end
      end
      ST_MR: begin
        if (!needs_mem(op_q) || accept) state_d = ST_RU;
      end
      ST_RU:  state_d = SkipEn ? ST_PCU : ST_MW;
      ST_MW:  state_d = ST_PCU;
      ST_PCU: begin
        if (op_q != OP_HALT) state_d = ST_IF;
      end
      default: state_d = ST_IF;
    endcase
  end

  // Datapath / output next-values
  always_comb begin
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    imm_d      = imm_q;
    ldm_d      = ldm_q;
    pc_d       = pc_q;
    halted_d   = halted_q;
    unique case (state_q)
      ST_IF: begin
        // Only reached without a request right after reset
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end else if (mem_ready) begin
          mem_req_d = 1'b0;
          ir_d      = mem_rdata;
        end
      end
      ST_MR: begin
        // Request goes out one cycle after the fetch handshake drops
        if (needs_mem(op_q)) begin
          if (!mem_req_q) begin
            mem_req_d  = 1'b1;
            mem_addr_d = (op_q == OP_LDI) ? (pc_q + XLEN'(1)) : load_addr;
          end else if (mem_ready) begin
            mem_req_d = 1'b0;
            if (op_q == OP_LDI) imm_d = mem_rdata;
            else                ldm_d = mem_rdata;
          end
        end
      end
      ST_PCU: begin
        if (op_q == OP_HALT) begin
          halted_d = 1'b1;
        end else begin
          // Next fetch is issued on entry to IF
          pc_d       = pc_q + ((op_q == OP_LDI) ? XLEN'(2) : XLEN'(1));
          mem_req_d  = 1'b1;
          mem_addr_d = pc_d;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ir_q       <= '0;
      imm_q      <= '0;
      ldm_q      <= '0;
      pc_q       <= '0;
      halted_q   <= 1'b0;
    end else begin
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      imm_q      <= imm_d;
      ldm_q      <= ldm_d;
      pc_q       <= pc_d;
      halted_q   <= halted_d;
    end
  end

  assign mem_req                  = mem_req_q;
  assign mem_addr                 = mem_addr_q;
  assign stage                    = 3'(state_q);
  assign current_instruction_type = op_q;
  assign load_imm_reg             = ir_q[9:5];
  assign load_mem_reg             = ir_q[9:5];
  assign alu_op_reg_res           = ir_q[9:5];
  assign alu_op_reg_0             = ir_q[14:10];
  assign alu_op_reg_1             = ir_q[19:15];
  assign alu_op                   = ir_q[25:20];
  assign load_imm_data            = imm_q;
  assign load_mem_data            = ldm_q;
  assign pc                       = pc_q;
  assign halted                   = halted_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instruction_sequencer
//   Directed bench: a small program in a behavioural memory, stage traces per
//   instruction, a delayed-ready operand load, reset while fetching, and HALT.
//   Expected stage traces follow STAGE_SKIP_EN when that macro is defined.
// ---------------------------------------------------------------------------
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [2:0]  stage;
  logic [4:0]  current_instruction_type;
  logic [4:0]  load_imm_reg, load_mem_reg;
  logic [4:0]  alu_op_reg_0, alu_op_reg_1, alu_op_reg_res;
  logic [31:0] load_imm_data, load_mem_data;
  logic [5:0]  alu_op;
  logic [31:0] pc;
  logic        halted;

  logic [31:0] mem [0:511];
  logic        ready;
  int          checks   = 0;
  int          failures = 0;

  // Stage traces encoded one nibble per visited stage as (stage+1)
`ifdef STAGE_SKIP_EN
  localparam logic [31:0] SEQ_PLAIN = 32'h0000_1351;   // 0,2,4,0
  localparam logic [31:0] SEQ_MEM   = 32'h0001_2351;   // 0,1,2,4,0
`else
  localparam logic [31:0] SEQ_PLAIN = 32'h0012_3451;   // 0,1,2,3,4,0
  localparam logic [31:0] SEQ_MEM   = 32'h0012_3451;
`endif

  instruction_sequencer dut (
    .clk                      (clk),
    .rst                      (rst),
    .mem_req                  (mem_req),
    .mem_addr                 (mem_addr),
    .mem_ready                (mem_ready),
    .mem_rdata                (mem_rdata),
    .stage                    (stage),
    .current_instruction_type (current_instruction_type),
    .load_imm_reg             (load_imm_reg),
    .load_mem_reg             (load_mem_reg),
    .alu_op_reg_0             (alu_op_reg_0),
    .alu_op_reg_1             (alu_op_reg_1),
    .alu_op_reg_res           (alu_op_reg_res),
    .load_imm_data            (load_imm_data),
    .load_mem_data            (load_mem_data),
    .alu_op                   (alu_op),
    .pc                       (pc),
    .halted                   (halted)
  );

  always #5 clk = ~clk;

  assign mem_ready = ready;
  assign mem_rdata = (mem_addr < 32'd512) ? mem[mem_addr[8:0]] : 32'h0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_stage(input string tag, input logic [2:0] s);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      tick();
      if (stage == s) hit = 1'b1;
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  // Runs one instruction from IF back to IF, recording the stage trace
  task automatic run_instr(input string tag, output logic [31:0] seq,
                           output logic [31:0] mr_addr, output logic [31:0] ru_imm);
    logic [2:0] last;
    bit left, done;
    seq = 32'h1; last = 3'd0; left = 1'b0; done = 1'b0;
    mr_addr = 32'h0; ru_imm = 32'h0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      if (stage != last) begin
        seq  = (seq << 4) | (32'(stage) + 32'd1);
        last = stage;
        if (stage != 3'd0) left = 1'b1;
        else if (left)     done = 1'b1;
      end
      if (stage == 3'd1 && mem_req) mr_addr = mem_addr;
      if (stage == 3'd2)            ru_imm  = load_imm_data;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] seq, mr_addr, ru_imm;
    int viol;

    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[0]     = 32'h0A41_0845;   // ALU_OP rd=2 rs0=2 rs1=2, ir[25:20]=0x24
    mem[1]     = 32'h0000_0000;   // NO_OP
    mem[2]     = 32'h0000_0006;   // undefined opcode -> NO_OP
    mem[3]     = 32'h0000_001F;   // undefined opcode -> NO_OP
    mem[4]     = 32'h0000_0061;   // LOAD_IMMEDIATE rd=3
    mem[5]     = 32'hDEAD_BEEF;   // immediate word
    mem[6]     = 32'h0080_0082;   // LOAD rd=4 addr=0x100
    mem[7]     = 32'h0000_0000;
    mem[8]     = 32'h0000_0000;
    mem[9]     = 32'h0000_0007;   // HALT
    mem[9'h100] = 32'hCAFE_F00D;

    rst   = 1'b1;
    ready = 1'b0;
    tick();
    tick();
    chk("rst_stage", 32'(stage), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imm", load_imm_data, 32'd0);
    chk("rst_ldm", load_mem_data, 32'd0);
    chk("rst_type", 32'(current_instruction_type), 32'd0);

    rst   = 1'b0;
    ready = 1'b1;
    tick();
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", mem_addr, 32'd0);

    // ALU_OP at address 0
    run_instr("alu", seq, mr_addr, ru_imm);
    chk("alu_seq", seq, SEQ_PLAIN);
    chk("alu_type", 32'(current_instruction_type), 32'd5);
    chk("alu_rs0", 32'(alu_op_reg_0), 32'd2);
    chk("alu_rs1", 32'(alu_op_reg_1), 32'd2);
    chk("alu_res", 32'(alu_op_reg_res), 32'd2);
    chk("alu_op", 32'(alu_op), 32'h24);
    chk("alu_pc", pc, 32'd1);

    // NO_OP and undefined opcodes
    run_instr("nop1", seq, mr_addr, ru_imm);
    chk("nop1_seq", seq, SEQ_PLAIN);
    run_instr("nop2", seq, mr_addr, ru_imm);
    chk("nop2_seq", seq, SEQ_PLAIN);
    chk("nop2_pc", pc, 32'd3);
    run_instr("nop3", seq, mr_addr, ru_imm);
    chk("nop3_pc", pc, 32'd4);

    // LOAD_IMMEDIATE at pc=4
    run_instr("ldi", seq, mr_addr, ru_imm);
    chk("ldi_seq", seq, SEQ_MEM);
    chk("ldi_mr_addr", mr_addr, 32'd5);
    chk("ldi_ru_imm", ru_imm, 32'hDEAD_BEEF);
    chk("ldi_reg", 32'(load_imm_reg), 32'd3);
    chk("ldi_pc", pc, 32'd6);

    // LOAD at pc=6 with ready held off for three cycles of the operand read
    wait_stage("ld_to_mr", 3'd1);
    ready = 1'b0;
    chk("ld_mr_idle", 32'(mem_req), 32'd0);
    tick();
    chk("ld_req_up", 32'(mem_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("ld_hold_stage", 32'(stage), 32'd1);
      chk("ld_hold_addr", mem_addr, 32'h100);
      chk("ld_hold_req", 32'(mem_req), 32'd1);
      chk("ld_hold_data", load_mem_data, 32'd0);
      tick();
    end
    chk("ld_wait_stage", 32'(stage), 32'd1);
    ready = 1'b1;
    tick();
    chk("ld_ru_stage", 32'(stage), 32'd2);
    chk("ld_data", load_mem_data, 32'hCAFE_F00D);
    chk("ld_req_drop", 32'(mem_req), 32'd0);
    wait_stage("ld_to_if", 3'd0);
    chk("ld_pc", pc, 32'd7);
    chk("ld_reg", 32'(load_mem_reg), 32'd4);
    chk("ld_imm_kept", load_imm_data, 32'hDEAD_BEEF);

    // Reset while a fetch at pc=7 is stalled
    ready = 1'b0;
    chk("if7_req", 32'(mem_req), 32'd1);
    chk("if7_addr", mem_addr, 32'd7);
    tick();
    tick();
    chk("if7_wait_stage", 32'(stage), 32'd0);
    chk("if7_wait_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pc", pc, 32'd0);
    chk("mid_rst_stage", 32'(stage), 32'd0);
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_ldm", load_mem_data, 32'd0);
    chk("mid_rst_imm", load_imm_data, 32'd0);
    tick();
    chk("mid_rst_req_held", 32'(mem_req), 32'd0);
    rst   = 1'b0;
    ready = 1'b1;
    tick();
    chk("post_rst_req", 32'(mem_req), 32'd1);
    chk("post_rst_addr", mem_addr, 32'd0);

    // Run the program again through to HALT at pc=9
    for (int i = 0; i < 400 && !halted; i++) tick();
    chk("halt_seen", 32'(halted), 32'd1);
    chk("halt_pc", pc, 32'd9);
    chk("halt_stage", 32'(stage), 32'd4);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req !== 1'b0 || stage !== 3'd4 || pc !== 32'd9 || halted !== 1'b1) viol++;
    end
    chk("halt_hold_viol", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
